// File: rtl/mul_seq_param.sv
// Sequential shift-and-add multiplier with optional early exit on an exhausted multiplier.
// Signed mode works on magnitudes and applies the sign fix on the way out.
module mul_seq_param #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               signed_i,
    input  logic               start,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic               done
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // The most-negative operand negates to itself, which read unsigned is the exact magnitude.
    always_comb begin
        a_mag = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
        b_mag = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        neg    <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (EARLY_EXIT && (mplier == '0)) begin
                        state <= FIN;
                    end else begin
                        if (mplier[0])
                            acc <= acc + mcand;
                        mplier <= mplier >> 1;
                        mcand  <= mcand << 1;
                        cnt    <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1))
                            state <= FIN;
                    end
                end
                FIN: begin
                    result <= neg ? -acc : acc;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq_param.sv
// Directed bench for mul_seq_param: one instance without and one with early exit.
module tb_mul_seq_param;
    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   a, b;
    logic           sg;
    logic           start0, start1;
    logic [2*W-1:0] res0, res1;
    logic           busy0, busy1, done0, done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_seq_param #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .a_i(a), .b_i(b), .signed_i(sg), .start(start0),
        .result(res0), .busy(busy0), .done(done0)
    );

    mul_seq_param #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .a_i(a), .b_i(b), .signed_i(sg), .start(start1),
        .result(res1), .busy(busy1), .done(done1)
    );

    typedef struct {
        bit           sel;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic         sv;
        logic [2*W-1:0] exp_res;
        int           exp_lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at #1 after the start edge; counts edges until done, result taken with done.
    task automatic wait_done(input bit sel, output logic [2*W-1:0] r, output int lat,
                             output int busy_n);
        lat    = 0;
        r      = 'x;
        busy_n = (sel ? busy1 : busy0) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            if (sel ? done1 : done0) begin
                r = sel ? res1 : res0;
                break;
            end
            if (sel ? busy1 : busy0) busy_n++;
        end
    endtask

    task automatic launch(input bit sel, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sv);
        @(negedge clk);
        a = av; b = bv; sg = sv;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        a = W'($urandom); b = W'($urandom); sg = 1'($urandom);
    endtask

    logic [2*W-1:0] r;
    int lat, busy_n, done_cnt;

    initial begin
        vecs[0]  = '{0, 8'd3,   8'd2,   0, 16'd6,     9};
        vecs[1]  = '{0, 8'd255, 8'd255, 0, 16'hFE01,  9};
        vecs[2]  = '{0, 8'd5,   8'd5,   0, 16'd25,    9};
        vecs[3]  = '{0, 8'hFD,  8'h05,  1, 16'hFFF1,  9};
        vecs[4]  = '{0, 8'h80,  8'h80,  1, 16'h4000,  9};
        vecs[5]  = '{0, 8'h80,  8'h01,  1, 16'hFF80,  9};
        vecs[6]  = '{0, 8'h7F,  8'h81,  1, 16'hC0FF,  9};
        vecs[7]  = '{1, 8'd200, 8'd1,   0, 16'd200,   3};
        vecs[8]  = '{1, 8'd7,   8'd0,   0, 16'd0,     2};
        vecs[9]  = '{1, 8'd4,   8'd3,   0, 16'd12,    4};
        vecs[10] = '{1, 8'd255, 8'd255, 0, 16'hFE01,  9};
        vecs[11] = '{1, 8'hFD,  8'h05,  1, 16'hFFF1,  5};
        vecs[12] = '{1, 8'h80,  8'h80,  1, 16'h4000,  9};
        vecs[13] = '{1, 8'h05,  8'hFD,  1, 16'hFFF1,  4};
        vecs[14] = '{1, 8'h00,  8'hFF,  1, 16'h0000,  3};
        vecs[15] = '{1, 8'h80,  8'hFF,  0, 16'h7F80,  9};

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; a = '0; b = '0; sg = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result0", res0, 0);
        check("reset_busy0", busy0, 0);
        check("reset_done0", done0, 0);
        check("reset_result1", res1, 0);
        check("reset_busy1", busy1, 0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            launch(vecs[i].sel, vecs[i].av, vecs[i].bv, vecs[i].sv);
            wait_done(vecs[i].sel, r, lat, busy_n);
            check($sformatf("vec%0d_result", i), r, vecs[i].exp_res);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            if (i == 0) check("vec0_busy_cycles", busy_n, 9);
        end

        // start mid-operation must be ignored
        launch(1, 8'd4, 8'd3, 0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        a = 8'd9; b = 8'd9; start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done1) begin
                done_cnt++;
                r = res1;
            end
        end
        check("ignore_start_done_pulses", done_cnt, 1);
        check("ignore_start_result", r, 16'd12);
        check("ignore_start_idle", busy1, 0);

        // start in the done cycle is accepted
        launch(1, 8'd4, 8'd3, 0);
        wait_done(1, r, lat, busy_n);
        check("b2b_first_result", r, 16'd12);
        a = 8'd5; b = 8'd5; sg = 1'b0; start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        check("b2b_busy", busy1, 1);
        wait_done(1, r, lat, busy_n);
        check("b2b_second_result", r, 16'd25);
        check("b2b_second_latency", lat, 5);

        // reset mid-operation aborts asynchronously
        launch(0, 8'd4, 8'd3, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        start1 = 1'b1;
        #1;
        check("rst_async_busy", busy0, 0);
        check("rst_async_done", done0, 0);
        check("rst_async_result", res0, 0);
        @(posedge clk); #1;
        start1 = 1'b0;
        @(negedge clk); rst = 1'b0;
        check("rst_start_ignored", busy1, 0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done0) done_cnt++;
        end
        check("rst_no_done", done_cnt, 0);
        launch(0, 8'd4, 8'd3, 0);
        wait_done(0, r, lat, busy_n);
        check("post_rst_result", r, 16'd12);
        check("post_rst_latency", lat, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_seq_param.md
MUL_SEQ_PARAM -- requirements
Module: mul_seq_param

Interface
REQ-001 The parameter WIDTH SHALL default to 8 and set the operand width; legal values are 2..32.
REQ-002 The parameter EARLY_EXIT SHALL default to 1; when set to 1, iteration stops as soon as the remaining multiplier bits are zero.
REQ-003 The port clk SHALL be an input, 1 bit wide, the single clock; all state updates on its rising edge.
REQ-004 The port rst SHALL be an input, 1 bit wide, an asynchronous active-high reset.
REQ-005 The port a_i SHALL be an input, WIDTH bits wide, the multiplicand.
REQ-006 The port b_i SHALL be an input, WIDTH bits wide, the multiplier.
REQ-007 The port signed_i SHALL be an input, 1 bit wide; 1 treats both operands as two's complement, 0 treats both as unsigned.
REQ-008 The port start SHALL be an input, 1 bit wide, the operation request.
REQ-009 The port result SHALL be an output, 2*WIDTH bits wide, the registered product.
REQ-010 The port busy SHALL be an output, 1 bit wide, high while an operation is in flight.
REQ-011 The port done SHALL be an output, 1 bit wide, a one-cycle pulse that coincides with the result update.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and FIN; busy = (state != IDLE).
REQ-013 In IDLE, start=1 at a rising edge SHALL capture a_i, b_i and signed_i and move the FSM to CALC.
- Signed mode: stores operand magnitudes plus a result-sign flag (sign_a XOR sign_b).
- Unsigned mode: stores raw operands and a clear sign flag.
- Clears the 2*WIDTH accumulator and the iteration counter.
REQ-014 Each CALC cycle SHALL process multiplier bit 0:
- If the bit is 1, add the left-shifted multiplicand into the accumulator.
- Shift the multiplier right by 1 and the multiplicand left by 1.
- Increment the counter.
REQ-015 CALC SHALL go to FIN after WIDTH iterations, or, if EARLY_EXIT=1, at the first CALC cycle whose multiplier register is zero; no accumulation occurs in that cycle.
REQ-016 The FIN edge SHALL perform the following actions together:
- Write result = accumulator, two's-complement negated if the sign flag is set.
- Pulse done=1 for exactly one cycle.
- Drop busy to 0 and return to IDLE.
REQ-017 Latency from the start edge to done=1 SHALL be WIDTH+1 edges when EARLY_EXIT=0.
REQ-018 With EARLY_EXIT=1, latency SHALL be k+2 edges, where k is the bit index of the highest set bit of the multiplier magnitude plus 1.
- k = 0 when the magnitude is zero; k is capped so total latency never exceeds WIDTH+1.
REQ-019 A start asserted while busy=1 SHALL be ignored; operands and mode in flight are unaffected.
REQ-020 A start asserted in the same cycle that done=1 SHALL be accepted, because the FSM is already in IDLE.
REQ-021 result SHALL hold its last value until the next FIN; inputs changing during CALC SHALL NOT affect the product.
REQ-022 Arithmetic SHALL be exact for all operand pairs:
- Unsigned products fit in 2*WIDTH bits.
- Signed mode handles the most-negative operand, whose magnitude 2^(WIDTH-1) is representable unsigned.
- (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) is representable.
REQ-023 A zero product SHALL never be negated into a non-zero value; the sign fix of 0 yields 0.

Reset
REQ-024 While rst=1, asynchronously and regardless of clk, the block SHALL force:
- state = IDLE;
- result = 0, busy = 0, done = 0;
- internal registers cleared.
REQ-025 Reset asserted mid-operation SHALL abort that operation with no done pulse; the first start after rst falls SHALL be processed normally.
REQ-026 start SHALL be ignored while rst=1.

Verification (WIDTH=8)
REQ-027 Bench SHALL check unsigned 3*2, EARLY_EXIT=0, expecting the following:
- result = 16'd6;
- done exactly 9 edges after the start edge;
- busy high for 9 cycles.
REQ-028 Bench SHALL check unsigned 255*255, expecting result = 16'd65025 (0xFE01).
- Also run 5*5 and expect 16'd25.
REQ-029 Bench SHALL check signed -3*5 (0xFD, 0x05), expecting result = 0xFFF1.
- Signed -128*-128 SHALL give 0x4000.
- Signed -128*1 SHALL give 0xFF80.
REQ-030 Bench SHALL check EARLY_EXIT=1, expecting the following:
- 200*1 gives result 16'd200 with done 3 edges after start.
- 7*0 gives 0 with done 2 edges after start.
- 4*3 gives 16'd12 with done 4 edges after start.
REQ-031 Bench SHALL pulse start=1 with new operands 3 cycles into a 4*3 operation; expect result = 12, a single done pulse, and no second operation.
REQ-032 Bench SHALL assert rst for 1 cycle 4 cycles into an operation; expect busy, done and result at 0 immediately.
- A following 4*3 SHALL complete with result 16'd12.
